// File: rtl/idct8x8_2d.sv
// 8x8 two-dimensional inverse DCT built around one shared 8-lane MAC datapath.
// A block is processed as 8 row passes (results stored transposed) followed by
// 8 column passes; each pass is 8 multiply-accumulate cycles plus 1 writeback.
// Optional macro IDCT_LEVEL_SHIFT_EN: column results get +128 and are clamped
// to 0..255 (JPEG pixel reconstruction).
// The cosine table below is tabulated for FRAC_W = 12.
module idct8x8_2d #(
   parameter int IN_W   = 32,
   parameter int FRAC_W = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [64*IN_W-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [64*IN_W-1:0]   out_data
);

   localparam int ACC_W = IN_W + FRAC_W + 5;
   localparam int CW    = FRAC_W + 2;

   localparam logic signed [ACC_W-1:0] RND_HALF =
      {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PASS, DONE} state_t;

   state_t state, state_next;
   logic [3:0] pass_cnt;
   logic [3:0] mac_cnt;
   logic       accept;
   logic       last_mac;

   logic signed [IN_W-1:0]  in_buf    [64];
   logic signed [IN_W-1:0]  trans_buf [64];
   logic signed [IN_W-1:0]  out_buf   [64];
   logic signed [ACC_W-1:0] acc  [8];
   logic signed [ACC_W-1:0] prod [8];
   logic signed [ACC_W-1:0] rnd  [8];
   logic signed [IN_W-1:0]  y_sat [8];
   logic signed [IN_W-1:0]  y_col [8];
   logic [5:0]              rd_idx;
   logic signed [IN_W-1:0]  in_k;

   // Cosine constant COEF[n][k]: fold the angle index (2n+1)k mod 32 onto the
   // first quadrant and look up the magnitude; k=0 carries the 1/sqrt(2) scale.
   function automatic logic signed [CW-1:0] coef(input logic [2:0] n, input logic [2:0] k);
      logic [6:0]           odd;
      logic [6:0]           kk;
      logic [4:0]           m;
      logic                 neg;
      logic signed [CW-1:0] mag;
      odd = {3'b000, n, 1'b1};
      kk  = {4'b0000, k};
      m   = 5'(odd * kk);
      if (m > 5'd16) m = 5'(6'd32 - {1'b0, m});
      neg = (m > 5'd8);
      if (neg) m = 5'd16 - m;
      case (m[3:0])
         4'd0:    mag = CW'(2048);
         4'd1:    mag = CW'(2009);
         4'd2:    mag = CW'(1892);
         4'd3:    mag = CW'(1703);
         4'd4:    mag = CW'(1448);
         4'd5:    mag = CW'(1138);
         4'd6:    mag = CW'(784);
         4'd7:    mag = CW'(400);
         default: mag = '0;
      endcase
      if (k == 3'd0) mag = CW'(1448);
      return neg ? -mag : mag;
   endfunction

   assign accept   = (state == IDLE) && in_valid;
   assign last_mac = (mac_cnt == 4'd8);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = PASS;
         end
         PASS: begin
            if (last_mac && (pass_cnt == 4'd15)) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pass and MAC-step counters; a pass is 8 MAC steps followed by writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt <= '0;
         mac_cnt  <= '0;
      end else if (accept) begin
         pass_cnt <= '0;
         mac_cnt  <= '0;
      end else if (state == PASS) begin
         if (last_mac) begin
            mac_cnt  <= '0;
            pass_cnt <= pass_cnt + 4'd1;
         end else begin
            mac_cnt <= mac_cnt + 4'd1;
         end
      end
   end

   // Operand fetch and the eight lane products; rows read the input block,
   // columns read the transpose buffer with the same row-major index.
   always_comb begin
      rd_idx = {pass_cnt[2:0], mac_cnt[2:0]};
      in_k   = pass_cnt[3] ? trans_buf[rd_idx] : in_buf[rd_idx];
      for (int n = 0; n < 8; n++) begin
         prod[n] = ACC_W'(in_k) * ACC_W'(coef(3'(n), mac_cnt[2:0]));
      end
   end

   // Lane accumulators, restarted with the first product of every pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 8; n++) acc[n] <= '0;
      end else if ((state == PASS) && !last_mac) begin
         for (int n = 0; n < 8; n++) begin
            if (mac_cnt == 4'd0) acc[n] <= prod[n];
            else                 acc[n] <= acc[n] + prod[n];
         end
      end
   end

   // Round half up, drop the fraction, saturate to the sample range and
   // optionally apply the pixel level shift for column results.
   always_comb begin
      for (int n = 0; n < 8; n++) begin
         rnd[n] = (acc[n] + RND_HALF) >>> FRAC_W;
         if (rnd[n] > SAT_MAX)      y_sat[n] = {1'b0, {(IN_W-1){1'b1}}};
         else if (rnd[n] < SAT_MIN) y_sat[n] = {1'b1, {(IN_W-1){1'b0}}};
         else                       y_sat[n] = rnd[n][IN_W-1:0];
      end
`ifdef IDCT_LEVEL_SHIFT_EN
      for (int n = 0; n < 8; n++) begin
         logic signed [IN_W+1:0] shifted;
         shifted = (IN_W+2)'(y_sat[n]) + (IN_W+2)'(128);
         if (shifted < 0)                   y_col[n] = '0;
         else if (shifted > (IN_W+2)'(255)) y_col[n] = IN_W'(8'd255);
         else                               y_col[n] = IN_W'(shifted[7:0]);
      end
`else
      for (int n = 0; n < 8; n++) y_col[n] = y_sat[n];
`endif
   end

   // Block storage: input latch on accept, transposed row results, and the
   // output block. These hold data only, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < 64; i++) in_buf[i] <= in_data[i*IN_W +: IN_W];
      end
      if ((state == PASS) && last_mac) begin
         for (int n = 0; n < 8; n++) begin
            if (!pass_cnt[3]) trans_buf[{3'(n), pass_cnt[2:0]}] <= y_sat[n];
            else              out_buf[{3'(n), pass_cnt[2:0]}]   <= y_col[n];
         end
      end
   end

   for (genvar g = 0; g < 64; g++) begin : g_out
      assign out_data[g*IN_W +: IN_W] = out_buf[g];
   end

endmodule

// File: tb/tb_idct8x8_2d.sv
// Directed self-checking bench for idct8x8_2d (honours IDCT_LEVEL_SHIFT_EN).
module tb_idct8x8_2d;

   localparam int IN_W = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [64*IN_W-1:0]   in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [64*IN_W-1:0]   out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   idct8x8_2d #(.IN_W(IN_W), .FRAC_W(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
      end
   endtask

   function automatic logic [31:0] elem(input int i);
      return out_data[i*IN_W +: IN_W];
   endfunction

   function automatic logic [64*IN_W-1:0] dc_block(input logic [31:0] v);
      logic [64*IN_W-1:0] b;
      b = '0;
      b[31:0] = v;
      return b;
   endfunction

   function automatic logic [64*IN_W-1:0] fill_block(input logic [31:0] v);
      logic [64*IN_W-1:0] b;
      for (int i = 0; i < 64; i++) b[i*IN_W +: IN_W] = v;
      return b;
   endfunction

   // Wait for IDLE, present one block and let it be accepted.
   task automatic start_block(input logic [64*IN_W-1:0] blk, input string tag);
      bit got;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (in_ready) got = 1;
      end
      check({tag, " idle_ready"}, 32'(got), 32'd1);
      in_data  = blk;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Count edges from acceptance until out_valid, watching in_ready stays low.
   task automatic wait_done(input string tag);
      int lat;
      bit got;
      bit busy_ok;
      lat = 0;
      got = 0;
      busy_ok = !in_ready;
      while (!got && lat < 300) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) got = 1;
         else if (in_ready) busy_ok = 0;
      end
      check({tag, " latency"}, 32'(lat), 32'd144);
      check({tag, " busy_in_ready_low"}, 32'(busy_ok), 32'd1);
   endtask

   task automatic release_block(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, " out_valid_after_release"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready_after_release"}, 32'(in_ready), 32'd1);
   endtask

   task automatic check_uniform(input string tag, input logic [31:0] v);
      for (int i = 0; i < 64; i++) check($sformatf("%s out[%0d]", tag, i), elem(i), v);
   endtask

   initial begin
      logic [31:0]        exp_v;
      logic [31:0]        snap [64];
      int                 ac_v [8];
      bit                 stable_ok;
      bit                 valid_ok;
      bit                 ready_ok;
      logic [64*IN_W-1:0] blk;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      repeat (3) @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;

      $display("[TB] zero block");
      start_block('0, "zero");
      wait_done("zero");
`ifdef IDCT_LEVEL_SHIFT_EN
      check_uniform("zero", 32'd128);
`else
      check_uniform("zero", 32'd0);
`endif
      release_block("zero");

      $display("[TB] DC 800");
      start_block(dc_block(32'd800), "dc800");
      wait_done("dc800");
`ifdef IDCT_LEVEL_SHIFT_EN
      check_uniform("dc800", 32'd228);
`else
      check_uniform("dc800", 32'd100);
`endif
      release_block("dc800");

      $display("[TB] DC -1024");
      start_block(dc_block(-32'sd1024), "dcm1024");
      wait_done("dcm1024");
`ifdef IDCT_LEVEL_SHIFT_EN
      check_uniform("dcm1024", 32'd0);
`else
      check_uniform("dcm1024", -32'sd128);
`endif
      release_block("dcm1024");

      $display("[TB] horizontal AC X[0][1]=100");
      blk = '0;
      blk[1*IN_W +: IN_W] = 32'd100;
      ac_v = '{17, 15, 10, 4, -4, -10, -15, -17};
      start_block(blk, "ac01");
      wait_done("ac01");
      for (int i = 0; i < 64; i++) begin
`ifdef IDCT_LEVEL_SHIFT_EN
         exp_v = 32'(ac_v[i % 8] + 128);
`else
         exp_v = 32'(ac_v[i % 8]);
`endif
         check($sformatf("ac01 out[%0d]", i), elem(i), exp_v);
      end
      release_block("ac01");

      $display("[TB] saturation all-max / all-min");
      start_block(fill_block(32'h7FFF_FFFF), "satmax");
      wait_done("satmax");
`ifdef IDCT_LEVEL_SHIFT_EN
      check("satmax out[0]", elem(0), 32'd255);
`else
      check("satmax out[0]", elem(0), 32'h7FFF_FFFF);
`endif
      release_block("satmax");
      start_block(fill_block(32'h8000_0000), "satmin");
      wait_done("satmin");
`ifdef IDCT_LEVEL_SHIFT_EN
      check("satmin out[0]", elem(0), 32'd0);
`else
      check("satmin out[0]", elem(0), 32'h8000_0000);
`endif
      release_block("satmin");

`ifdef IDCT_LEVEL_SHIFT_EN
      $display("[TB] DC 4000 clamp");
      start_block(dc_block(32'd4000), "dc4000");
      wait_done("dc4000");
      check("dc4000 out[0]", elem(0), 32'd255);
      check("dc4000 out[63]", elem(63), 32'd255);
      release_block("dc4000");
`endif

      $display("[TB] backpressure");
      start_block(dc_block(32'd800), "bp");
      wait_done("bp");
      for (int i = 0; i < 64; i++) snap[i] = elem(i);
      stable_ok = 1;
      valid_ok  = 1;
      ready_ok  = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         in_data  = dc_block(-32'sd1024);
         @(posedge clk);
         #1;
         for (int i = 0; i < 64; i++) if (elem(i) !== snap[i]) stable_ok = 0;
         if (out_valid !== 1'b1) valid_ok = 0;
         if (in_ready !== 1'b0) ready_ok = 0;
      end
      in_valid = 1'b0;
      check("bp out_data_stable", 32'(stable_ok), 32'd1);
      check("bp out_valid_held", 32'(valid_ok), 32'd1);
      check("bp no_accept", 32'(ready_ok), 32'd1);
`ifdef IDCT_LEVEL_SHIFT_EN
      check("bp out[5]", elem(5), 32'd228);
`else
      check("bp out[5]", elem(5), 32'd100);
`endif
      release_block("bp");
      in_data  = '0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("bp next_accept", 32'(in_ready), 32'd0);
      wait_done("bp_next");
`ifdef IDCT_LEVEL_SHIFT_EN
      check("bp_next out[9]", elem(9), 32'd128);
`else
      check("bp_next out[9]", elem(9), 32'd0);
`endif
      release_block("bp_next");

      $display("[TB] reset mid-pass");
      start_block(dc_block(-32'sd1024), "rst");
      repeat (5*9 + 3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      start_block(dc_block(32'd800), "after_rst");
      wait_done("after_rst");
`ifdef IDCT_LEVEL_SHIFT_EN
      check_uniform("after_rst", 32'd228);
`else
      check_uniform("after_rst", 32'd100);
`endif
      release_block("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
